pe_feeder: RTL and testbench
============================

# pe_feeder

Sequencer that drives a single PE with ifmap/filter operand pairs and collects its partial sum. It holds two small operand scratchpads loaded by the global buffer. On `start` it clears the PE, streams one ACC_NUM-long window of operand pairs with `pe_en` high, waits for the PE result, then offers the psum downstream with a valid/ready handshake. It sits between the buffer/controller and each PE instance, one feeder per PE.

## Interface
- `ACC_NUM`, 3: operand pairs per window; must match the PE's accumulation count; ≥1.
- `DEPTH`, 8: entries per scratchpad; ≥ACC_NUM; power of two.
- `PSUM_LAT`, 1: cycles from the last `pe_en` beat until `pe_psum` is valid; ≥1.
- `AW`, $clog2(DEPTH): scratchpad address width (derived).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load_valid` in 1: scratchpad write request.
- `load_ready` out 1: write accepted this cycle; equals (state==IDLE).
- `load_sel` in 1: 0 = ifmap scratchpad, 1 = filter scratchpad.
- `load_addr` in AW: write address.
- `load_data` in 8: write data.
- `start` in 1: begin one window; honoured only in IDLE.
- `ifmap_base` in AW: first ifmap address of the window; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `pe_clr` out 1: active-high PE clear, one cycle.
- `pe_en` out 1: PE accumulate enable.
- `pe_ifmap` out 8: ifmap operand to PE.
- `pe_filter` out 8: filter operand to PE.
- `pe_psum` in 8: PE result.
- `psum_valid` out 1: result available.
- `psum_ready` in 1: downstream accepts the result.
- `psum_data` out 8: captured result.

## Operation
- FSM states: IDLE, CLEAR, FEED, WAIT, HOLD.
- IDLE:
  - A write is committed when `load_valid` is high (`load_ready` is high in IDLE).
  - `start` latches `ifmap_base` into `base_q` and moves to CLEAR.
  - If `start` and `load_valid` occur together, both take effect. The written value is visible to the window.
- CLEAR: `pe_clr`=1 for one cycle; then FEED with `idx`=0.
- FEED: lasts ACC_NUM cycles.
  - `pe_en`=1.
  - `pe_ifmap` = ifmap[(`base_q`+`idx`) mod DEPTH], so addresses wrap.
  - `pe_filter` = filter[`idx`].
  - After `idx`==ACC_NUM-1, go to WAIT with `wcnt`=0.
- WAIT: `pe_en`=0 and operands are 0. After PSUM_LAT cycles, register `pe_psum` into `psum_data` and go to HOLD.
- HOLD:
  - `psum_valid`=1; `psum_data` is stable.
  - On `psum_valid`&&`psum_ready`, return to IDLE.
  - `start` is ignored in HOLD.
- `load_valid` and `start` outside IDLE are ignored; nothing is written and nothing is queued.
- Operand outputs are registered. They are 0 whenever `pe_en`=0.
- Arithmetic: the feeder performs none. `psum_data` is `pe_psum` verbatim (8 bits).

## Timing
- Reset (asynchronous, `rst`=0):
  - FSM goes to IDLE.
  - All scratchpad entries, `idx`, `wcnt`, `base_q` and `psum_data` are 0.
  - `busy`, `pe_clr`, `pe_en`, `pe_ifmap`, `pe_filter` and `psum_valid` are 0; `load_ready`=1.
  - A reset mid-window aborts it with no psum emitted.
- Latency, with `start` sampled at edge 0:
  - `pe_clr` is high in cycle 1.
  - `pe_en` is high in cycles 2..ACC_NUM+1.
  - `psum_valid` rises in cycle ACC_NUM+PSUM_LAT+2.
- With `psum_ready` held high, `psum_valid` lasts one cycle.
- IDLE is re-entered the next cycle. The minimum `start`-to-`start` spacing is ACC_NUM+PSUM_LAT+3 cycles.
- Back-pressure: HOLD persists indefinitely and `psum_data` does not change.

## Structure
- Shared package `pe_pkg`: state enum `feeder_state_t`, the 8-bit `data_t` typedef, and the default ACC_NUM/DEPTH constants.
- Sub-module `pe_scratchpad`: DEPTH×8 register file with one write port, one combinational read port and async reset. It is instantiated twice (ifmap, filter).

## Test plan
- Reset defaults: assert reset mid-FEED. All outputs go to their reset values immediately, `load_ready`=1, and no `psum_valid` follows.
- Basic window (ACC_NUM=3, PSUM_LAT=1):
  - Stimulus: ifmap[0..2]=1,2,3; filter[0..2]=4,5,6; `ifmap_base`=0. A bench PE model returns the sum of the low bytes of the products.
  - Expected: `pe_clr` in cycle 1; pairs (1,4),(2,5),(3,6) in cycles 2–4; `psum_valid` in cycle 6 with `psum_data`=32.
- Wrap-around: DEPTH=8, `ifmap_base`=6, ifmap[6]=10, ifmap[7]=20, ifmap[0]=30, filter all 1 → `pe_ifmap` sequence 10,20,30; psum 60.
- Back-pressure: hold `psum_ready`=0 for 5 cycles. `psum_valid` stays 1, `psum_data` stays constant, and a `start` pulse during HOLD is ignored; accept returns to IDLE the next cycle.
- Load gating: `load_valid` during FEED is not written (`load_ready`=0, a readback window shows the old data). `load_valid` together with `start` in IDLE writes filter[0]=7, and 7 appears in the first FEED beat.
- Overflow pass-through: ifmap=16,16,16 and filter=16,16,16. The model gives a psum of 0 (low byte of 256×3); `psum_data`=0, and only a single `psum_valid` pulse is produced.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE feeder slice.
package pe_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned ACC_NUM_DEF = 3;
   localparam int unsigned DEPTH_DEF   = 8;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      WAIT  = 3'd3,
      HOLD  = 3'd4
   } feeder_state_t;

endpackage

// File: rtl/pe_scratchpad.sv
// DEPTH x 8 operand register file: one write port, one combinational read port.
module pe_scratchpad
   import pe_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rd_data_c
);

   data_t mem [DEPTH];

   // Storage array; every entry clears on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read so the feeder can register the operand directly.
   always_comb begin
      rd_data_c = mem[raddr];
   end

endmodule

// File: rtl/pe_feeder.sv
// Sequencer feeding one PE a window of operand pairs and handing its psum downstream.
module pe_feeder
   import pe_pkg::*;
#(
   parameter int unsigned ACC_NUM  = ACC_NUM_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned PSUM_LAT = 1,
   localparam int unsigned AW      = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic          load_sel,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data,
   input  logic          start,
   input  logic [AW-1:0] ifmap_base,
   output logic          busy,
   output logic          pe_clr,
   output logic          pe_en,
   output logic [7:0]    pe_ifmap,
   output logic [7:0]    pe_filter,
   input  logic [7:0]    pe_psum,
   output logic          psum_valid,
   input  logic          psum_ready,
   output logic [7:0]    psum_data
);

   localparam int unsigned WW = (PSUM_LAT > 1) ? $clog2(PSUM_LAT) : 1;

   feeder_state_t state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0] base_q, base_d;
   data_t         psum_d;
   logic          load_we;
   logic [AW-1:0] rd_addr_if, rd_addr_flt;
   logic [7:0]    if_rd_c, flt_rd_c;
   logic          feed_d;

   // Scratchpads only accept writes while idle; load_sel picks the target.
   pe_scratchpad #(.DEPTH(DEPTH), .AW(AW)) u_ifmap_spad (
      .clk       (clk),
      .rst       (rst),
      .we        (load_we && !load_sel),
      .waddr     (load_addr),
      .wdata     (load_data),
      .raddr     (rd_addr_if),
      .rd_data_c (if_rd_c)
   );

   pe_scratchpad #(.DEPTH(DEPTH), .AW(AW)) u_filter_spad (
      .clk       (clk),
      .rst       (rst),
      .we        (load_we && load_sel),
      .waddr     (load_addr),
      .wdata     (load_data),
      .raddr     (rd_addr_flt),
      .rd_data_c (flt_rd_c)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, counter and read-address logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      base_d  = base_q;
      psum_d  = psum_data;
      load_we = 1'b0;

      case (state_q)
         IDLE: begin
            load_we = load_valid;
            if (start) begin
               base_d  = ifmap_base;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            idx_d   = '0;
            state_d = FEED;
         end
         FEED: begin
            if (idx_q == AW'(ACC_NUM - 1)) begin
               wcnt_d  = '0;
               state_d = WAIT;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         WAIT: begin
            if (wcnt_q == WW'(PSUM_LAT - 1)) begin
               psum_d  = pe_psum;
               state_d = HOLD;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         HOLD: begin
            if (psum_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Operands for the beat about to be presented; ifmap address wraps mod DEPTH.
      feed_d      = (state_d == FEED);
      rd_addr_if  = base_d + idx_d;
      rd_addr_flt = idx_d;
   end

   // Counters, captured base/psum and registered outputs derived from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q      <= '0;
         wcnt_q     <= '0;
         base_q     <= '0;
         psum_data  <= '0;
         load_ready <= 1'b1;
         busy       <= 1'b0;
         pe_clr     <= 1'b0;
         pe_en      <= 1'b0;
         pe_ifmap   <= '0;
         pe_filter  <= '0;
         psum_valid <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         wcnt_q     <= wcnt_d;
         base_q     <= base_d;
         psum_data  <= psum_d;
         load_ready <= (state_d == IDLE);
         busy       <= (state_d != IDLE);
         pe_clr     <= (state_d == CLEAR);
         pe_en      <= feed_d;
         pe_ifmap   <= feed_d ? if_rd_c : 8'd0;
         pe_filter  <= feed_d ? flt_rd_c : 8'd0;
         psum_valid <= (state_d == HOLD);
      end
   end

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder with a behavioural accumulate-and-hold PE.
module tb_pe_feeder;

   localparam int ACC       = 3;
   localparam int LAT       = 1;
   localparam int VALID_CYC = ACC + LAT + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid, load_ready, load_sel;
   logic [2:0] load_addr;
   logic [7:0] load_data;
   logic       start;
   logic [2:0] ifmap_base;
   logic       busy, pe_clr, pe_en;
   logic [7:0] pe_ifmap, pe_filter, pe_psum;
   logic       psum_valid, psum_ready;
   logic [7:0] psum_data;

   int total = 0;
   int bad   = 0;

   logic [15:0] beat_q [$];
   logic [7:0]  psum_q [$];
   logic [15:0] mon_beat;
   logic [7:0]  mon_psum;
   logic [7:0]  acc;

   pe_feeder #(.ACC_NUM(ACC), .DEPTH(8), .PSUM_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_sel   (load_sel),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start),
      .ifmap_base (ifmap_base),
      .busy       (busy),
      .pe_clr     (pe_clr),
      .pe_en      (pe_en),
      .pe_ifmap   (pe_ifmap),
      .pe_filter  (pe_filter),
      .pe_psum    (pe_psum),
      .psum_valid (psum_valid),
      .psum_ready (psum_ready),
      .psum_data  (psum_data)
   );

   always #5 clk = ~clk;

   // PE model: 8-bit accumulator of product low bytes, result valid one cycle after the last beat.
   always @(posedge clk or negedge rst) begin
      if (!rst)        acc <= 8'd0;
      else if (pe_clr) acc <= 8'd0;
      else if (pe_en)  acc <= acc + pe_ifmap * pe_filter;
   end
   assign pe_psum = acc;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: operand beats and accepted psums are popped from the scoreboard queues.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (pe_en) begin
            if (beat_q.size() == 0) begin
               chk("unexpected_beat", {pe_ifmap, pe_filter}, -1);
            end else begin
               mon_beat = beat_q.pop_front();
               chk("beat_pair", {pe_ifmap, pe_filter}, mon_beat);
            end
         end else begin
            chk("idle_operands", {pe_ifmap, pe_filter}, 0);
         end
         if (psum_valid && psum_ready) begin
            if (psum_q.size() == 0) begin
               chk("unexpected_psum", psum_data, -1);
            end else begin
               mon_psum = psum_q.pop_front();
               chk("psum_data", psum_data, mon_psum);
            end
         end
      end
   end

   task automatic load(input logic sel, input int addr, input int data);
      load_valid = 1'b1;
      load_sel   = sel;
      load_addr  = 3'(addr);
      load_data  = 8'(data);
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   task automatic push_beat(input int i, input int f);
      beat_q.push_back({8'(i), 8'(f)});
   endtask

   // Start pulse (edge 0), optionally with a simultaneous scratchpad write.
   task automatic kick(input int base, input logic lv, input logic lsel, input int laddr, input int ldata);
      start      = 1'b1;
      ifmap_base = 3'(base);
      load_valid = lv;
      load_sel   = lsel;
      load_addr  = 3'(laddr);
      load_data  = 8'(ldata);
      @(posedge clk); #1;
      start      = 1'b0;
      load_valid = 1'b0;
   endtask

   // Cycle-accurate walk through one window, optional hold phase and return to idle.
   task automatic check_window(input int exp, input int hold, input bit feed_load);
      bit seen;
      seen = 1'b0;
      for (int k = 1; k <= 30 && !seen; k++) begin
         @(negedge clk);
         if (k <= ACC + 1) begin
            chk("pe_clr", pe_clr, int'(k == 1));
            chk("pe_en", pe_en, int'(k >= 2));
         end
         if (psum_valid) begin
            chk("valid_cycle", k, VALID_CYC);
            seen = 1'b1;
         end
         if (feed_load && k == 2) begin
            chk("load_ready_feed", load_ready, 0);
            load_valid = 1'b1;
            load_sel   = 1'b0;
            load_addr  = 3'd0;
            load_data  = 8'd99;
         end
         if (feed_load && k == 3) load_valid = 1'b0;
      end
      if (!seen) begin
         chk("valid_timeout", 0, 1);
      end else begin
         for (int h = 0; h < hold; h++) begin
            chk("hold_valid", psum_valid, 1);
            chk("hold_data", psum_data, exp);
            chk("hold_busy", busy, 1);
            @(posedge clk); #1;
            start      = (h == 1);
            ifmap_base = 3'd2;
         end
         if (hold > 0) begin
            start      = 1'b0;
            psum_ready = 1'b1;
            @(negedge clk);
            chk("accept_valid", psum_valid, 1);
         end
      end
      @(negedge clk);
      chk("idle_valid", psum_valid, 0);
      chk("idle_load_ready", load_ready, 1);
      chk("idle_busy", busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b0;
      load_valid = 1'b0;
      load_sel   = 1'b0;
      load_addr  = 3'd0;
      load_data  = 8'd0;
      start      = 1'b0;
      ifmap_base = 3'd0;
      psum_ready = 1'b1;

      #12;
      chk("rst_load_ready", load_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_pe_clr", pe_clr, 0);
      chk("rst_pe_en", pe_en, 0);
      chk("rst_psum_valid", psum_valid, 0);
      chk("rst_psum_data", psum_data, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Basic window: 1*4 + 2*5 + 3*6 = 32.
      load(0, 0, 1); load(0, 1, 2); load(0, 2, 3);
      load(1, 0, 4); load(1, 1, 5); load(1, 2, 6);
      push_beat(1, 4); push_beat(2, 5); push_beat(3, 6);
      psum_q.push_back(8'd32);
      kick(0, 0, 0, 0, 0);
      check_window(32, 0, 0);

      // Wrap-around from base 6; a write to ifmap[0] during FEED must be dropped.
      load(0, 6, 10); load(0, 7, 20); load(0, 0, 30);
      load(1, 0, 1); load(1, 1, 1); load(1, 2, 1);
      push_beat(10, 1); push_beat(20, 1); push_beat(30, 1);
      psum_q.push_back(8'd60);
      kick(6, 0, 0, 0, 0);
      check_window(60, 0, 1);

      // Readback (ifmap[0] still 30), filter[0]=7 written with start, back-pressure: 210+2+3.
      push_beat(30, 7); push_beat(2, 1); push_beat(3, 1);
      psum_q.push_back(8'd215);
      psum_ready = 1'b0;
      kick(0, 1, 1, 0, 7);
      check_window(215, 5, 0);

      // Reset in the middle of FEED: two beats, then abort with no psum.
      push_beat(30, 7); push_beat(2, 1);
      kick(0, 0, 0, 0, 0);
      @(negedge clk); @(negedge clk); @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_pe_en", pe_en, 0);
      chk("abort_pe_clr", pe_clr, 0);
      chk("abort_busy", busy, 0);
      chk("abort_psum_valid", psum_valid, 0);
      chk("abort_load_ready", load_ready, 1);
      chk("abort_operands", {pe_ifmap, pe_filter}, 0);
      chk("abort_psum_data", psum_data, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_no_valid", psum_valid, 0);
      @(posedge clk); #1;

      // Overflow pass-through: each product 256 contributes low byte 0.
      load(0, 0, 16); load(0, 1, 16); load(0, 2, 16);
      load(1, 0, 16); load(1, 1, 16); load(1, 2, 16);
      push_beat(16, 16); push_beat(16, 16); push_beat(16, 16);
      psum_q.push_back(8'd0);
      kick(0, 0, 0, 0, 0);
      check_window(0, 0, 0);
      repeat (4) @(negedge clk);

      chk("beats_left", beat_q.size(), 0);
      chk("psums_left", psum_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
